// File: rtl/exec_muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit that owns HI/LO and serves MTHI/MTLO/MFHI/MFLO.
// Works on operand magnitudes and applies sign correction in a single FIX cycle.
module exec_muldiv_unit #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_valid,
    input  logic [2:0]        i_op,
    input  logic [DATA_W-1:0] i_rs_reg,
    input  logic [DATA_W-1:0] i_rt_reg,
    input  logic              i_flush,
    output logic [DATA_W-1:0] o_hi,
    output logic [DATA_W-1:0] o_lo,
    output logic [DATA_W-1:0] o_mf_data,
    output logic              o_busy,
    output logic              os_stall,
    output logic              o_done,
    output logic              o_div_by_zero
);
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_MUL  = 3'd1;
    localparam logic [2:0] S_DIV  = 3'd2;
    localparam logic [2:0] S_FIX  = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    localparam logic [2:0] OP_MTHI = 3'd4;
    localparam logic [2:0] OP_MTLO = 3'd5;
    localparam logic [2:0] OP_MFHI = 3'd6;
    localparam logic [2:0] OP_MFLO = 3'd7;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

    logic [2:0]          state;
    logic [CNT_W-1:0]    cnt;
    logic [2*DATA_W-1:0] acc;
    logic [DATA_W-1:0]   opnd;
    logic [DATA_W-1:0]   hi;
    logic [DATA_W-1:0]   lo;
    logic                is_div;
    logic                dbz;
    logic                neg_q;
    logic                neg_r;

    logic                req;
    logic                accept;
    logic                a_neg;
    logic                b_neg;
    logic [DATA_W-1:0]   a_mag;
    logic [DATA_W-1:0]   b_mag;
    logic [DATA_W:0]     mul_sum;
    logic [DATA_W:0]     div_sh;
    logic                div_ge;
    logic [DATA_W-1:0]   div_rem;
    logic [2*DATA_W-1:0] mul_next;
    logic [2*DATA_W-1:0] div_next;
    logic [2*DATA_W-1:0] prod_fix;
    logic [DATA_W-1:0]   q_fix;
    logic [DATA_W-1:0]   r_fix;

    assign req    = i_valid & ~i_flush;
    assign accept = req & (state == S_IDLE) & ~i_op[2];

    // i_op[0] set means the unsigned variant
    assign a_neg = ~i_op[0] & i_rs_reg[DATA_W-1];
    assign b_neg = ~i_op[0] & i_rt_reg[DATA_W-1];
    assign a_mag = a_neg ? -i_rs_reg : i_rs_reg;
    assign b_mag = b_neg ? -i_rt_reg : i_rt_reg;

    // Multiply: acc = {partial product, remaining multiplier bits}
    assign mul_sum  = {1'b0, acc[2*DATA_W-1:DATA_W]} + {1'b0, opnd & {DATA_W{acc[0]}}};
    assign mul_next = {mul_sum, acc[DATA_W-1:1]};

    // Divide: acc = {partial remainder, dividend bits shifting into quotient}
    assign div_sh   = acc[2*DATA_W-1:DATA_W-1];
    assign div_ge   = div_sh >= {1'b0, opnd};
    assign div_rem  = div_sh[DATA_W-1:0] - opnd;
    assign div_next = div_ge ? {div_rem, acc[DATA_W-2:0], 1'b1}
                             : {div_sh[DATA_W-1:0], acc[DATA_W-2:0], 1'b0};

    // A zero divisor leaves |A| as remainder; negating by A's sign restores the raw dividend
    assign prod_fix = neg_q ? -acc : acc;
    assign q_fix    = dbz ? '1 : (neg_q ? -acc[DATA_W-1:0] : acc[DATA_W-1:0]);
    assign r_fix    = neg_r ? -acc[2*DATA_W-1:DATA_W] : acc[2*DATA_W-1:DATA_W];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= S_IDLE;
            cnt    <= '0;
            acc    <= '0;
            opnd   <= '0;
            hi     <= '0;
            lo     <= '0;
            is_div <= 1'b0;
            dbz    <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        state  <= i_op[1] ? S_DIV : S_MUL;
                        cnt    <= '0;
                        acc    <= {{DATA_W{1'b0}}, (i_op[1] ? a_mag : b_mag)};
                        opnd   <= i_op[1] ? b_mag : a_mag;
                        is_div <= i_op[1];
                        dbz    <= i_op[1] & (i_rt_reg == '0);
                        neg_q  <= a_neg ^ b_neg;
                        neg_r  <= a_neg;
                    end else if (req && i_op == OP_MTHI) begin
                        hi <= i_rs_reg;
                    end else if (req && i_op == OP_MTLO) begin
                        lo <= i_rs_reg;
                    end
                end
                S_MUL, S_DIV: begin
                    if (i_flush) begin
                        state <= S_IDLE;
                    end else begin
                        acc <= (state == S_DIV) ? div_next : mul_next;
                        if (cnt == CNT_LAST) state <= S_FIX;
                        else                 cnt   <= cnt + CNT_W'(1);
                    end
                end
                S_FIX: begin
                    if (i_flush) begin
                        state <= S_IDLE;
                    end else begin
                        state <= S_DONE;
                        if (is_div) begin
                            hi <= r_fix;
                            lo <= q_fix;
                        end else begin
                            hi <= prod_fix[2*DATA_W-1:DATA_W];
                            lo <= prod_fix[DATA_W-1:0];
                        end
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign o_hi          = hi;
    assign o_lo          = lo;
    assign o_busy        = (state != S_IDLE);
    assign os_stall      = req & o_busy;
    assign o_done        = (state == S_DONE);
    assign o_div_by_zero = o_done & dbz;

    always_comb begin
        o_mf_data = '0;
        if (i_valid && i_op == OP_MFHI) o_mf_data = hi;
        if (i_valid && i_op == OP_MFLO) o_mf_data = lo;
    end
endmodule

// File: tb/tb_exec_muldiv_unit.sv
// Bench for exec_muldiv_unit: directed scenarios plus a scoreboard of expected HI/LO results
// popped whenever the unit pulses o_done.
module tb_exec_muldiv_unit;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         i_valid = 1'b0;
    logic [2:0]   i_op = 3'd0;
    logic [W-1:0] i_rs_reg = '0;
    logic [W-1:0] i_rt_reg = '0;
    logic         i_flush = 1'b0;
    logic [W-1:0] o_hi, o_lo, o_mf_data;
    logic         o_busy, os_stall, o_done, o_div_by_zero;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dbz;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;

    exec_muldiv_unit #(.DATA_W(W), .CNT_W(6)) dut (
        .clk(clk), .rst(rst), .i_valid(i_valid), .i_op(i_op),
        .i_rs_reg(i_rs_reg), .i_rt_reg(i_rt_reg), .i_flush(i_flush),
        .o_hi(o_hi), .o_lo(o_lo), .o_mf_data(o_mf_data), .o_busy(o_busy),
        .os_stall(os_stall), .o_done(o_done), .o_div_by_zero(o_div_by_zero)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: every o_done pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        exp_t e;
        if (rst && o_done === 1'b1) begin
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL sb_unexpected_done got hi=%h lo=%h", o_hi, o_lo);
            end else begin
                e = sb.pop_front();
                if ({o_hi, o_lo, o_div_by_zero} !== {e.hi, e.lo, e.dbz}) begin
                    bad++;
                    $display("FAIL sb_result got hi=%h lo=%h dbz=%b exp hi=%h lo=%h dbz=%b",
                             o_hi, o_lo, o_div_by_zero, e.hi, e.lo, e.dbz);
                end
            end
        end
    end

    function automatic exp_t model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t   e;
        longint sa, sbv, q, r;
        logic [63:0] p;
        sa  = longint'($signed(a));
        sbv = longint'($signed(b));
        e.dbz = 1'b0;
        e.hi = '0;
        e.lo = '0;
        case (op)
            3'd0: begin p = 64'(sa * sbv); e.hi = p[63:32]; e.lo = p[31:0]; end
            3'd1: begin p = {32'b0, a} * {32'b0, b}; e.hi = p[63:32]; e.lo = p[31:0]; end
            default: begin
                if (b == '0) begin
                    e.hi = a; e.lo = '1; e.dbz = 1'b1;
                end else if (op == 3'd2) begin
                    q = sa / sbv; r = sa % sbv;
                    e.lo = q[31:0]; e.hi = r[31:0];
                end else begin
                    e.lo = a / b; e.hi = a % b;
                end
            end
        endcase
        return e;
    endfunction

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'h0000_0000;
            1: return 32'h0000_0001;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            default: return $urandom();
        endcase
    endfunction

    // Wait (bounded) for o_done; counts cycles where o_div_by_zero shows without o_done
    task automatic wait_done(output int at, output int stray);
        at = -1;
        stray = 0;
        for (int i = 0; i < 60 && at < 0; i++) begin
            if (o_div_by_zero === 1'b1 && o_done !== 1'b1) stray++;
            if (o_done === 1'b1) at = cyc;
            else begin @(posedge clk); #1; end
        end
    endtask

    // Issue one op from IDLE, push its expectation, return its done latency
    task automatic run_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input exp_t e, output int lat, output int stray);
        int t0, at;
        sb.push_back(e);
        i_valid = 1'b1; i_op = op; i_rs_reg = a; i_rt_reg = b;
        t0 = cyc;
        @(posedge clk); #1;
        i_valid = 1'b0;
        wait_done(at, stray);
        lat = (at < 0) ? -1 : at - t0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        #2;
        total++;
        if ({o_hi, o_lo} !== '0) begin
            bad++; $display("FAIL reset_hilo got=%h exp=0", {o_hi, o_lo});
        end
        total++;
        if ({o_busy, os_stall, o_done, o_div_by_zero} !== 4'b0) begin
            bad++; $display("FAIL reset_flags got=%b exp=0000", {o_busy, os_stall, o_done, o_div_by_zero});
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_mult_timing();
        int t0, at, stray;
        sb.push_back('{hi: 32'hFFFF_FFFF, lo: 32'hFFFF_FFEB, dbz: 1'b0});
        i_valid = 1'b1; i_op = 3'd0; i_rs_reg = 32'hFFFF_FFFD; i_rt_reg = 32'd7;
        t0 = cyc;
        @(posedge clk); #1;
        i_valid = 1'b0;
        #1;
        total++;
        if ({o_busy, os_stall} !== 2'b10) begin
            bad++; $display("FAIL mult_busy_nostall got=%b exp=10", {o_busy, os_stall});
        end
        wait_done(at, stray);
        total++;
        if (at - t0 !== 34) begin
            bad++; $display("FAIL mult_latency got=%0d exp=34", at - t0);
        end
        @(posedge clk); #1;
        total++;
        if ({o_busy, o_hi, o_lo} !== {1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFEB}) begin
            bad++; $display("FAIL mult_after got busy=%b hi=%h lo=%h exp 0 FFFFFFFF FFFFFFEB", o_busy, o_hi, o_lo);
        end
    endtask

    task automatic test_mul_vectors();
        int lat, stray;
        run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, '{hi: 32'hFFFF_FFFE, lo: 32'h0000_0001, dbz: 1'b0}, lat, stray);
        total++;
        if (lat !== 34) begin bad++; $display("FAIL multu_latency got=%0d exp=34", lat); end
        run_op(3'd0, 32'h8000_0000, 32'h8000_0000, '{hi: 32'h4000_0000, lo: 32'h0, dbz: 1'b0}, lat, stray);
        run_op(3'd0, 32'h7FFF_FFFF, 32'hFFFF_FFFF, model(3'd0, 32'h7FFF_FFFF, 32'hFFFF_FFFF), lat, stray);
    endtask

    task automatic test_div_vectors();
        int lat, stray;
        run_op(3'd2, 32'hFFFF_FFF9, 32'd2, '{hi: 32'hFFFF_FFFF, lo: 32'hFFFF_FFFD, dbz: 1'b0}, lat, stray);
        total++;
        if (lat !== 34) begin bad++; $display("FAIL div_latency got=%0d exp=34", lat); end
        run_op(3'd3, 32'h1234_5678, 32'd0, '{hi: 32'h1234_5678, lo: 32'hFFFF_FFFF, dbz: 1'b1}, lat, stray);
        total++;
        if (stray !== 0) begin bad++; $display("FAIL dbz_without_done got=%0d exp=0", stray); end
        run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, '{hi: 32'h0, lo: 32'h8000_0000, dbz: 1'b0}, lat, stray);
        run_op(3'd2, 32'hFFFF_FFF9, 32'd0, '{hi: 32'hFFFF_FFF9, lo: 32'hFFFF_FFFF, dbz: 1'b1}, lat, stray);
        run_op(3'd3, 32'hFFFF_FFFF, 32'd10, '{hi: 32'h5, lo: 32'h1999_9999, dbz: 1'b0}, lat, stray);
    endtask

    task automatic test_stall_mf();
        int t0, nst, done_at;
        logic [W-1:0] mf_done;
        sb.push_back('{hi: 32'h0, lo: 32'h0000_001E, dbz: 1'b0});
        i_valid = 1'b1; i_op = 3'd0; i_rs_reg = 32'd5; i_rt_reg = 32'd6;
        t0 = cyc;
        @(posedge clk); #1;
        i_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        i_valid = 1'b1; i_op = 3'd7; i_rs_reg = '0; i_rt_reg = '0;
        nst = 0; done_at = -1; mf_done = '0;
        for (int k = 3; k <= 35; k++) begin
            #1;
            if (k <= 34 && os_stall !== 1'b1) nst++;
            if (o_done === 1'b1) begin done_at = cyc - t0; mf_done = o_mf_data; end
            if (k < 35) begin @(posedge clk); #1; end
        end
        total++;
        if (nst !== 0) begin bad++; $display("FAIL stall_window got=%0d_gaps exp=0", nst); end
        total++;
        if (done_at !== 34 || mf_done !== 32'h1E) begin
            bad++; $display("FAIL mf_with_done got at=%0d mf=%h exp at=34 mf=0000001E", done_at, mf_done);
        end
        total++;
        if ({os_stall, o_mf_data} !== {1'b0, 32'h0000_001E}) begin
            bad++; $display("FAIL mflo_accept got stall=%b mf=%h exp 0 0000001E", os_stall, o_mf_data);
        end
        @(posedge clk); #1;
        i_op = 3'd4; i_rs_reg = 32'hAAAA_5555;
        #1;
        total++;
        if (os_stall !== 1'b0) begin bad++; $display("FAIL mthi_stall got=%b exp=0", os_stall); end
        @(posedge clk); #1;
        i_op = 3'd5; i_rs_reg = 32'h0F0F_1234;
        @(posedge clk); #1;
        i_valid = 1'b0;
        total++;
        if ({o_hi, o_lo, o_busy} !== {32'hAAAA_5555, 32'h0F0F_1234, 1'b0}) begin
            bad++; $display("FAIL mthi_mtlo got hi=%h lo=%h busy=%b exp AAAA5555 0F0F1234 0", o_hi, o_lo, o_busy);
        end
        i_valid = 1'b1; i_op = 3'd6;
        #1;
        total++;
        if (o_mf_data !== 32'hAAAA_5555) begin bad++; $display("FAIL mfhi got=%h exp=AAAA5555", o_mf_data); end
        @(posedge clk); #1;
        i_valid = 1'b0;
    endtask

    task automatic test_flush();
        logic [W-1:0] h0, l0;
        int nd;
        h0 = o_hi; l0 = o_lo;
        i_valid = 1'b1; i_op = 3'd3; i_rs_reg = 32'd1000; i_rt_reg = 32'd7;
        @(posedge clk); #1;
        i_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        i_flush = 1'b1; i_valid = 1'b1; i_op = 3'd6;
        #1;
        total++;
        if (os_stall !== 1'b0) begin bad++; $display("FAIL flush_beats_stall got=%b exp=0", os_stall); end
        @(posedge clk); #1;
        i_flush = 1'b0; i_valid = 1'b0;
        total++;
        if ({o_busy, o_hi, o_lo} !== {1'b0, h0, l0}) begin
            bad++; $display("FAIL flush_idle got busy=%b hi=%h lo=%h exp 0 %h %h", o_busy, o_hi, o_lo, h0, l0);
        end
        nd = 0;
        repeat (40) begin @(posedge clk); #1; if (o_done === 1'b1) nd++; end
        total++;
        if (nd !== 0) begin bad++; $display("FAIL flush_no_done got=%0d exp=0", nd); end
        i_valid = 1'b1; i_flush = 1'b1; i_op = 3'd4; i_rs_reg = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        i_valid = 1'b0; i_flush = 1'b0;
        total++;
        if (o_hi !== h0) begin bad++; $display("FAIL flush_drops_mthi got=%h exp=%h", o_hi, h0); end
    endtask

    task automatic test_reset_midflight();
        i_valid = 1'b1; i_op = 3'd2; i_rs_reg = 32'd100; i_rt_reg = 32'd3;
        @(posedge clk); #1;
        i_valid = 1'b0;
        repeat (4) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        total++;
        if ({o_hi, o_lo, o_mf_data, o_busy, os_stall, o_done, o_div_by_zero} !== '0) begin
            bad++; $display("FAIL async_reset got hi=%h lo=%h busy=%b done=%b", o_hi, o_lo, o_busy, o_done);
        end
        @(posedge clk); #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (o_busy !== 1'b0) begin bad++; $display("FAIL reset_stays_idle got=%b exp=0", o_busy); end
    endtask

    // Ops presented back to back; each one is held while os_stall is high
    task automatic test_back_to_back();
        logic [2:0] op;
        logic [W-1:0] a, b;
        int waits, timeouts;
        timeouts = 0;
        for (int n = 0; n < 24; n++) begin
            op = 3'($urandom_range(0, 3));
            a = pick(); b = pick();
            i_valid = 1'b1; i_op = op; i_rs_reg = a; i_rt_reg = b;
            waits = 0;
            #1;
            while (os_stall === 1'b1 && waits < 50) begin
                @(posedge clk); #2;
                waits++;
            end
            if (waits >= 50) timeouts++;
            else sb.push_back(model(op, a, b));
            @(posedge clk); #1;
        end
        i_valid = 1'b0;
        for (int i = 0; i < 60 && sb.size() != 0; i++) begin @(posedge clk); #1; end
        total++;
        if (timeouts !== 0) begin bad++; $display("FAIL b2b_accept_timeout got=%0d exp=0", timeouts); end
        total++;
        if (sb.size() !== 0) begin bad++; $display("FAIL b2b_drain got=%0d_pending exp=0", sb.size()); end
    endtask

    initial begin
        test_reset();
        test_mult_timing();
        test_mul_vectors();
        test_div_vectors();
        test_stall_mf();
        test_flush();
        test_reset_midflight();
        test_back_to_back();
        total++;
        if (sb.size() !== 0) begin bad++; $display("FAIL sb_leftover got=%0d exp=0", sb.size()); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
